// File: rtl/cpu_mult_acc_cell.sv
// Pipelined multiply-accumulate cell.
// The stages are: input register, PIPE_DEPTH product stages, then one accumulate/output stage.
// The whole pipe advances together when the output is free or being consumed.
module cpu_mult_acc_cell #(
   parameter int unsigned WIDTH_A    = 32,
   parameter int unsigned WIDTH_B    = 32,
   parameter int unsigned ACC_WIDTH  = 72,
   parameter int unsigned PIPE_DEPTH = 2,
   parameter int unsigned SATURATE   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH_A-1:0]   src1,
   input  logic [WIDTH_B-1:0]   src2,
   input  logic                 src1_signed,
   input  logic                 src2_signed,
   input  logic [1:0]           op,
   input  logic                 acc_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] result,
   output logic                 overflow
);

   localparam int unsigned PW  = WIDTH_A + WIDTH_B;
   localparam int unsigned MSB = ACC_WIDTH - 1;
   localparam int unsigned L   = PIPE_DEPTH - 1;

   localparam logic [ACC_WIDTH-1:0] ALL_ONES = '1;
   localparam logic [ACC_WIDTH-1:0] SMAX     = ALL_ONES >> 1;
   localparam logic [ACC_WIDTH-1:0] SMIN     = ~SMAX;

   typedef enum logic [1:0] {
      OpMul  = 2'b00,
      OpMac  = 2'b01,
      OpMsub = 2'b10,
      OpRead = 2'b11
   } op_e;

   if (ACC_WIDTH < PW) begin : gen_acc_width_check
      $error("cpu_mult_acc_cell: ACC_WIDTH must be >= WIDTH_A + WIDTH_B");
   end
   if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : gen_depth_check
      $error("cpu_mult_acc_cell: PIPE_DEPTH must be within 1..4");
   end

   // Input register
   logic               in_v_q;
   logic [WIDTH_A:0]   a_q;
   logic [WIDTH_B:0]   b_q;
   logic               sgn_q;
   op_e                op_q;
   logic               clr_q;

   // Product stages
   logic [PIPE_DEPTH-1:0] pv_q;
   logic [PW-1:0]         pp_q   [PIPE_DEPTH];
   op_e                   pop_q  [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] psgn_q;
   logic [PIPE_DEPTH-1:0] pclr_q;

   // Accumulate/output stage
   logic                 out_valid_q;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 ovf_q, ovf_d;

   logic                 advance;
   logic [PW-1:0]        prod;
   logic [ACC_WIDTH-1:0] p_ext;
   logic [ACC_WIDTH-1:0] base;
   logic [ACC_WIDTH:0]   sum;
   logic [ACC_WIDTH:0]   diff;

   assign advance   = out_ready || !out_valid_q;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign result    = acc_q;
   assign overflow  = ovf_q;

   // Only the low PW bits of the (WIDTH_A+1)x(WIDTH_B+1) signed product are kept.
   // Sign-extending both operands to PW bits and multiplying modulo 2^PW gives the same bits.
   assign prod = {{(WIDTH_B - 1){a_q[WIDTH_A]}}, a_q} * {{(WIDTH_A - 1){b_q[WIDTH_B]}}, b_q};

   // Extend the final-stage product and form the candidate sum/difference
   always_comb begin
      p_ext = ACC_WIDTH'(pp_q[L]);
      if (psgn_q[L] && pp_q[L][PW-1]) begin
         p_ext = p_ext | (ALL_ONES << PW);
      end
      base = pclr_q[L] ? '0 : acc_q;
      sum  = {1'b0, base} + {1'b0, p_ext};
      diff = {1'b0, base} - {1'b0, p_ext};
   end

   // Next accumulator value, overflow detection and optional clamping
   always_comb begin
      acc_d = base;
      ovf_d = 1'b0;
      unique case (pop_q[L])
         OpMul: begin
            acc_d = p_ext;
         end
         OpMac: begin
            acc_d = sum[MSB:0];
            ovf_d = psgn_q[L] ? ((base[MSB] == p_ext[MSB]) && (sum[MSB] != base[MSB]))
                              : sum[ACC_WIDTH];
         end
         OpMsub: begin
            acc_d = diff[MSB:0];
            ovf_d = psgn_q[L] ? ((base[MSB] != p_ext[MSB]) && (diff[MSB] != base[MSB]))
                              : diff[ACC_WIDTH];
         end
         OpRead: begin
            acc_d = base;
         end
         default: begin
            acc_d = base;
         end
      endcase
      // A signed overflow always goes in the direction of the sign of base.
      if (SATURATE != 0 && ovf_d) begin
         if (psgn_q[L]) begin
            acc_d = base[MSB] ? SMIN : SMAX;
         end else begin
            acc_d = (pop_q[L] == OpMac) ? ALL_ONES : '0;
         end
      end
   end

   // Stage valids and architectural state; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         in_v_q      <= 1'b0;
         pv_q        <= '0;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else if (advance) begin
         in_v_q      <= in_valid;
         pv_q[0]     <= in_v_q;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            pv_q[k] <= pv_q[k-1];
         end
         out_valid_q <= pv_q[L];
         if (pv_q[L]) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
         end
      end
   end

   // Datapath registers; their contents only matter when the matching valid is set
   always_ff @(posedge clk) begin
      if (advance) begin
         a_q       <= {src1_signed & src1[WIDTH_A-1], src1};
         b_q       <= {src2_signed & src2[WIDTH_B-1], src2};
         sgn_q     <= src1_signed | src2_signed;
         op_q      <= op_e'(op);
         clr_q     <= acc_clr;
         pp_q[0]   <= prod;
         pop_q[0]  <= op_q;
         psgn_q[0] <= sgn_q;
         pclr_q[0] <= clr_q;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            pp_q[k]   <= pp_q[k-1];
            pop_q[k]  <= pop_q[k-1];
            psgn_q[k] <= psgn_q[k-1];
            pclr_q[k] <= pclr_q[k-1];
         end
      end
   end

endmodule

// File: doc/cpu_mult_acc_cell.md
Name: cpu_mult_acc_cell

Overview:
Parametrised, pipelined multiply-accumulate cell for the CPU execute/custom-instruction datapath. It is the successor to the fixed 32x32 two-stage multiplier cell.
- Generalises operand width and pipeline depth.
- Adds a valid/ready handshake with back-pressure.
- Adds an internal accumulator with MUL/MAC/MSUB/READ modes, overflow detection and optional saturation.

Parameters:
WIDTH_A, 32, width of src1 (2..64)
WIDTH_B, 32, width of src2 (2..64)
ACC_WIDTH, 72, accumulator/result width; must be >= WIDTH_A+WIDTH_B (elaboration error otherwise)
PIPE_DEPTH, 2, product pipeline stages after input register (1..4)
SATURATE, 0, 1 = clamp accumulator on overflow; 0 = wrap

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  cell accepts operation this cycle
src1  in  WIDTH_A  operand A
src2  in  WIDTH_B  operand B
src1_signed  in  1  treat src1 as two's complement
src2_signed  in  1  treat src2 as two's complement
op  in  2  00 MUL, 01 MAC, 10 MSUB, 11 READ
acc_clr  in  1  treat accumulator as zero for this operation
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  ACC_WIDTH  new accumulator value
overflow  out  1  overflow flag for this result (qualified by out_valid)

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset:
  - All stage valid bits, accumulator, result and overflow are cleared to 0.
  - in_ready is 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight operations. No out_valid is produced for them.
- Acceptance: an operation is accepted when in_valid && in_ready on a rising edge. src*, flags, op and acc_clr are sampled at that edge.
- Advance: advance = out_ready || !out_valid. The whole pipeline (input register, PIPE_DEPTH product stages, accumulate/output stage) moves only when advance=1.
  - in_ready = advance.
  - Bubbles propagate as invalid stages. There is no bubble collapsing.
- Latency: without stall, an op accepted at edge t gives out_valid=1 after edge t+PIPE_DEPTH+1. Throughput is 1 op/cycle.
- out_valid/result/overflow hold stable while out_valid && !out_ready.
- Product:
  - Each operand is extended by 1 bit, using its sign flag (sign-extend if signed, zero-extend if not).
  - Multiply signed (WIDTH_A+1)x(WIDTH_B+1) and keep the low WIDTH_A+WIDTH_B bits (P).
  - P is sign-extended to ACC_WIDTH if src1_signed||src2_signed, else zero-extended.
- Accumulate stage (final stage; acc is updated only when its stage is valid and advance=1):
  - base = acc_clr ? 0 : acc.
  - MUL: acc = P.
  - MAC: acc = base+P.
  - MSUB: acc = base-P.
  - READ: acc = base. Operands are ignored and overflow=0.
  - result = new acc.
- Dependency: back-to-back MAC/MSUB ops are naturally ordered because the accumulation happens in a single stage. No forwarding hazard exists.
- Overflow, evaluated per MAC/MSUB:
  - Signed mode (either sign flag set): operands of the add have the same sign and the sum sign differs. For MSUB, check a-b equivalently.
  - Unsigned mode: carry-out on MAC, borrow on MSUB.
  - MUL never overflows, since ACC_WIDTH >= product width.
- SATURATE=1: on overflow, acc is clamped.
  - Signed: max 0111..1 or min 1000..0, by the direction of the true result.
  - Unsigned: all-ones on carry, 0 on borrow.
  - overflow is still reported as 1.
- SATURATE=0: acc wraps modulo 2^ACC_WIDTH.
- Simultaneous: acc_clr with op MUL has no effect beyond MUL. acc_clr with READ returns 0 and clears acc.
- Stall with in_valid held: the operation is not accepted and must be held by the producer. The cell does not sample it.

Test Plan:
- Unsigned MUL, defaults: src1=0xFFFFFFFF, src2=0xFFFFFFFF, flags 0 -> result=0x00_FFFFFFFE_00000001, overflow=0, out_valid exactly 3 cycles after accept.
- Mixed sign MUL: src1=0xFFFFFFFF signed (-1), src2=3 unsigned -> result=-3 sign-extended to 72 bits (0xFF_FFFFFFFF_FFFFFFFD).
- MAC chain, 4 back-to-back ops (acc_clr on first), signed 2*3, 4*5, -1*7, 10*10 -> results 6, 26, 19, 119 on consecutive cycles, no gaps.
- Overflow: ACC_WIDTH=64, WIDTH_A=WIDTH_B=32, signed; preload acc=0x7FFFFFFF_FFFFFFFF via MUL-free path (MAC from clr of 0x7FFFFFFF*0x7FFFFFFF, then MACs), then MAC +1*1 at max -> SATURATE=0: result=0x8000000000000000, overflow=1; SATURATE=1: result=0x7FFFFFFFFFFFFFFF, overflow=1.
- Back-pressure: hold out_ready=0 for 5 cycles with pipeline full -> in_ready=0, result held stable; release -> 4 results in order, none lost or duplicated.
- Reset mid-flight: accept 2 MACs, assert reset for 1 cycle -> no out_valid, acc=0; next READ returns 0.
